adder_4bit: RTL and testbench

- Registered 4-bit binary adder with carry-in and carry-out.
- Built as a ripple chain of full-adder cells with one output register stage.
- Leaf arithmetic block for small datapaths.
- Also provides valid tracking plus zero and signed-overflow status flags.

---
 rtl/adder_4bit.sv | 75 +++++++
 tb/tb_adder_4bit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/adder_4bit.sv
// Registered ripple-carry adder with carry-in/out, zero and signed-overflow flags.
// Latency 1 cycle; accepts an operation every cycle, no backpressure.
module adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             ovf_d;
  logic             zero_d;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Carries into and out of the MSB disagree exactly when the signed result overflows.
  assign ovf_d  = c[WIDTH] ^ c[WIDTH-1];
  assign zero_d = (s == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      S         <= '0;
      Cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= s;
        Cout <= c[WIDTH];
        ovf  <= ovf_d;
        zero <= zero_d;
      end
    end
  end

endmodule

// One-bit full adder cell used as the ripple chain element.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: tb/tb_adder_4bit.sv
// Directed-vector and exhaustive bench for adder_4bit, including reset interaction.
module tb_adder_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic       in_valid;
  logic [3:0] S;
  logic       Cout;
  logic       ovf;
  logic       zero;
  logic       out_valid;

  int tests;
  int failed;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       vld;
    logic [3:0] es;
    logic       ec;
    logic       eo;
    logic       ez;
    logic       ev;
  } vec_t;

  vec_t tbl[11];

  adder_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .S         (S),
    .Cout      (Cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] es, input logic ec,
                       input logic eo, input logic ez, input logic ev);
    tests++;
    if ({S, Cout, ovf, zero, out_valid} !== {es, ec, eo, ez, ev}) begin
      failed++;
      $display("FAIL %s: got S=%0d Cout=%b ovf=%b zero=%b out_valid=%b, expected S=%0d Cout=%b ovf=%b zero=%b out_valid=%b",
               name, S, Cout, ovf, zero, out_valid, es, ec, eo, ez, ev);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic vld);
    A        = a;
    B        = b;
    Cin      = cin;
    in_valid = vld;
  endtask

  initial begin
    logic [4:0] sum;
    logic [3:0] es;
    logic       eo;

    tests  = 0;
    failed = 0;

    tbl[0]  = '{4'd0,  4'd0,  1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{4'd1,  4'd6,  1'b1, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{4'd15, 4'd1,  1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{4'd7,  4'd1,  1'b0, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{4'd8,  4'd8,  1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{4'd5,  4'd2,  1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{4'd15, 4'd15, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{4'd3,  4'd4,  1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'd15, 4'd15, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'd0,  4'd0,  1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'd9,  4'd6,  1'b1, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1};

    // Reset held for two edges while a valid operation is offered: reset wins.
    rst = 1'b1;
    drive(4'd5, 4'd5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("reset", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    rst = 1'b0;
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].vld);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].es, tbl[i].ec, tbl[i].eo, tbl[i].ez, tbl[i].ev);
    end

    // Exhaustive back-to-back sweep with a reset pulse landing mid-stream.
    for (int k = 0; k < 512; k++) begin
      logic [8:0] kv;
      kv = 9'(k);
      drive(kv[3:0], kv[7:4], kv[8], 1'b1);
      rst = (k == 200);
      @(negedge clk);
      if (k == 200) begin
        check("sweep_reset", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        sum = 5'(kv[3:0]) + 5'(kv[7:4]) + 5'(kv[8]);
        es  = sum[3:0];
        eo  = (kv[3] == kv[7]) && (es[3] != kv[3]);
        check($sformatf("sweep a=%0d b=%0d cin=%0d", kv[3:0], kv[7:4], kv[8]),
              es, sum[4], eo, (es == 4'd0), 1'b1);
      end
    end
    rst = 1'b0;

    drive(4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    sum = 5'd15 + 5'd15 + 5'd1;
    check("final_hold", sum[3:0], sum[4], 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
